scs_engine: RTL

Parametrised successor to the single-purpose payload checksum block. It sits between the packet buffer RAM (a synchronous single-port RAM with 1-cycle read latency) and the packet control logic. It streams `payload_len` words starting at a programmable base address and computes a weighted shift-and-add checksum of configurable width. In generate mode it writes the checksum MSB-first directly after the payload. In verify mode it compares the computed checksum against the one stored there.

---
 rtl/scs_engine.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/scs_engine.sv
// Weighted shift-and-add checksum engine over the packet buffer RAM.
// Verify mode is built only when SCS_VERIFY_EN is defined; otherwise mode is ignored.
//   state     | meaning
//   IDLE      | wait for mem_ready, latch job parameters
//   RD_ADDR   | payload address presented, RAM latency cycle
//   RD_DATA   | accumulate weighted payload word, advance
//   WR_SETUP  | load checksum byte, raise write strobe
//   WR_STROBE | write happens, drop strobe, advance
//   CK_ADDR   | stored checksum byte address presented
//   CK_DATA   | compare stored byte against computed byte
//   DONE      | publish result, pulse work_complete
module scs_engine #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 8,
    parameter int SUM_WIDTH     = 16,
    parameter int WEIGHT_SHIFTS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_ready,
    input  logic                     mode,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [RAM_ADDR_BITS-1:0] payload_len,
    output logic [RAM_ADDR_BITS-1:0] address,
    output logic                     write_enable,
    output logic [RAM_WIDTH-1:0]     mem_input,
    input  logic [RAM_WIDTH-1:0]     mem_output,
    output logic                     busy,
    output logic                     work_complete,
    output logic                     check_ok,
    output logic [SUM_WIDTH-1:0]     scs_value
);
    localparam int NB = SUM_WIDTH / RAM_WIDTH;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int WW = (WEIGHT_SHIFTS > 1) ? $clog2(WEIGHT_SHIFTS) : 1;
`ifdef SCS_VERIFY_EN
    localparam logic VERIFY_BUILT = 1'b1;
`else
    localparam logic VERIFY_BUILT = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_SETUP, WR_STROBE, CK_ADDR, CK_DATA, DONE
    } state_t;

    state_t                   state_q, state_d, tail_state;
    logic                     mode_q, mode_d, mode_eff;
    logic [RAM_ADDR_BITS-1:0] len_q, len_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [WW-1:0]            wt_q, wt_d;
    logic [KW-1:0]            k_q, k_d;
    logic [SUM_WIDTH-1:0]     sum_q, sum_d;
    logic [RAM_ADDR_BITS-1:0] address_q, address_d;
    logic                     write_enable_q, write_enable_d;
    logic [RAM_WIDTH-1:0]     mem_input_q, mem_input_d;
    logic                     busy_q, busy_d;
    logic                     work_complete_q, work_complete_d;
    logic                     check_ok_q, check_ok_d;
    logic [SUM_WIDTH-1:0]     scs_value_q, scs_value_d;
    logic [SUM_WIDTH-1:0]     sum_shifted;
    logic [RAM_WIDTH-1:0]     cur_byte;
`ifdef SCS_VERIFY_EN
    logic                     match_q, match_d;
`endif

    // Checksum bytes leave MSB-first: byte k is the k-th chunk from the top.
    assign sum_shifted = sum_q >> (RAM_WIDTH * (NB - 1 - int'(k_q)));
    assign cur_byte    = sum_shifted[RAM_WIDTH-1:0];
    assign mode_eff    = mode & VERIFY_BUILT;
    assign tail_state  = mode_q ? CK_ADDR : WR_SETUP;

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        len_d           = len_q;
        idx_d           = idx_q;
        wt_d            = wt_q;
        k_d             = k_q;
        sum_d           = sum_q;
        address_d       = address_q;
        write_enable_d  = write_enable_q;
        mem_input_d     = mem_input_q;
        busy_d          = busy_q;
        work_complete_d = 1'b0;
        check_ok_d      = check_ok_q;
        scs_value_d     = scs_value_q;
`ifdef SCS_VERIFY_EN
        match_d         = match_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_ready) begin
                    mode_d     = mode_eff;
                    len_d      = payload_len;
                    address_d  = base_addr;
                    sum_d      = '0;
                    idx_d      = '0;
                    wt_d       = '0;
                    k_d        = '0;
                    busy_d     = 1'b1;
                    check_ok_d = 1'b0;
`ifdef SCS_VERIFY_EN
                    match_d    = 1'b1;
`endif
                    if (payload_len == '0) begin
                        state_d = mode_eff ? CK_ADDR : WR_SETUP;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                sum_d     = sum_q + (SUM_WIDTH'(mem_output) << wt_q);
                address_d = address_q + 1'b1;
                idx_d     = idx_q + 1'b1;
                wt_d      = (wt_q == WW'(WEIGHT_SHIFTS - 1)) ? '0 : wt_q + 1'b1;
                state_d   = (idx_d == len_q) ? tail_state : RD_ADDR;
            end
            WR_SETUP: begin
                mem_input_d    = cur_byte;
                write_enable_d = 1'b1;
                state_d        = WR_STROBE;
            end
            WR_STROBE: begin
                write_enable_d = 1'b0;
                address_d      = address_q + 1'b1;
                k_d            = k_q + 1'b1;
                if (k_q == KW'(NB - 1)) begin
                    scs_value_d     = sum_q;
                    work_complete_d = 1'b1;
                    state_d         = DONE;
                end else begin
                    state_d = WR_SETUP;
                end
            end
`ifdef SCS_VERIFY_EN
            CK_ADDR: state_d = CK_DATA;
            CK_DATA: begin
                if (mem_output != cur_byte) match_d = 1'b0;
                address_d = address_q + 1'b1;
                k_d       = k_q + 1'b1;
                if (k_q == KW'(NB - 1)) begin
                    check_ok_d      = match_d;
                    scs_value_d     = sum_q;
                    work_complete_d = 1'b1;
                    state_d         = DONE;
                end else begin
                    state_d = CK_ADDR;
                end
            end
`endif
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            mode_q          <= 1'b0;
            len_q           <= '0;
            idx_q           <= '0;
            wt_q            <= '0;
            k_q             <= '0;
            sum_q           <= '0;
            address_q       <= '0;
            write_enable_q  <= 1'b0;
            mem_input_q     <= '0;
            busy_q          <= 1'b0;
            work_complete_q <= 1'b0;
            check_ok_q      <= 1'b0;
            scs_value_q     <= '0;
`ifdef SCS_VERIFY_EN
            match_q         <= 1'b1;
`endif
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            wt_q            <= wt_d;
            k_q             <= k_d;
            sum_q           <= sum_d;
            address_q       <= address_d;
            write_enable_q  <= write_enable_d;
            mem_input_q     <= mem_input_d;
            busy_q          <= busy_d;
            work_complete_q <= work_complete_d;
            check_ok_q      <= check_ok_d;
            scs_value_q     <= scs_value_d;
`ifdef SCS_VERIFY_EN
            match_q         <= match_d;
`endif
        end
    end

    assign address       = address_q;
    assign write_enable  = write_enable_q;
    assign mem_input     = mem_input_q;
    assign busy          = busy_q;
    assign work_complete = work_complete_q;
    assign check_ok      = check_ok_q;
    assign scs_value     = scs_value_q;

endmodule
